ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Synthesizable AHB-Lite slave that converts AHB transfers into single-port word-addressed SRAM accesses. It is the DUT-side endpoint driven by the slave agent's signal bundle. It sits directly downstream of the bus: it consumes `haddr`/`htrans`/`hwrite`/`hwdata`/`hwstrb` and produces `hrdata`/`hresp`/`hreadyout`. Its features are programmable wait-state insertion, byte-lane writes and the two-cycle AHB ERROR response.

## Interface
- `ADDRWIDTH`, default 32: address bus width.
- `DATAWIDTH`, default 32: data bus width; must be 32 or 64.
- `MEM_DEPTH`, default 1024: number of DATAWIDTH-bit words.
- `WAIT_STATES`, default 0: wait cycles inserted into every NONSEQ/SEQ data phase, range 0–15.

- `hclk`: input, 1, the single clock; all logic is on its rising edge.
- `hreset`: input, 1, synchronous, active-high reset.
- `hsel`: input, 1, slave select.
- `haddr`: input, ADDRWIDTH, byte address.
- `hburst`: input, 3, burst type; informational only, no behavioural effect.
- `hsize`: input, 3, transfer size, 2^hsize bytes.
- `htrans`: input, 2, IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hwrite`: input, 1, 1 = write.
- `hwdata`: input, DATAWIDTH, write data, valid in the data phase.
- `hwstrb`: input, DATAWIDTH/8, byte-lane strobes, valid in the data phase.
- `hready`: input, 1, bus-level HREADY (HREADYIN).
- `hrdata`: output, DATAWIDTH, read data.
- `hresp`: output, 1, 0 = OKAY, 1 = ERROR.
- `hreadyout`: output, 1, 0 = extend the data phase.

## Operation
- **Address-phase accept:** a transfer is accepted on an edge where `hsel & hready & htrans[1]`. At that edge, register the address, hsize, hwrite, word index `haddr >> log2(DATAWIDTH/8)` and byte offset.
- **IDLE/BUSY or hsel=0 with hready=1:** no access; the next data phase is zero-wait OKAY.
- **Error conditions, checked at accept:**
  - word index >= MEM_DEPTH;
  - hsize > log2(DATAWIDTH/8);
  - address not aligned to 2^hsize.
  - An errored transfer never touches memory.
- **State machine:**
  - IDLE: on an OK accept with WAIT_STATES=0, stay in IDLE (data phase completes next cycle). With WAIT_STATES>0, go to WAIT and load `wcnt = WAIT_STATES`. On an error accept, go to ERR1.
  - WAIT: `hreadyout=0` and decrement `wcnt`. On the edge where `wcnt` reaches 1, go to DONE.
  - DONE: `hreadyout=1`; complete the transfer. The address phase is sampled in this cycle, with the same transitions as IDLE.
  - ERR1: `hresp=1`, `hreadyout=0`; unconditionally go to ERR2.
  - ERR2: `hresp=1`, `hreadyout=1`; the address phase is sampled here, with transitions as in IDLE.
- **Write:** committed on the edge that ends the data phase (`hreadyout=1`). The effective lane mask is `hwstrb` AND the size/offset mask, so only lanes `[offset, offset+2^hsize)` are written. `hwdata` is sampled only on that edge.
- **Read:** `hrdata` is the full word at the registered index, valid whenever `hreadyout=1` in a read data phase. In every other cycle `hrdata` holds its previous value.
- **Read-after-write:** a read whose data phase immediately follows a write to the same word returns the newly written data.
- **Widths:** `wcnt` is 4 bits; the lane mask is DATAWIDTH/8 bits.

## Timing
- **Reset values:** `hreadyout=1`, `hresp=0`, `hrdata=0`; state IDLE; `wcnt=0`. Memory contents are not reset.
- **Reset mid-transfer:** aborts the transfer. A write in WAIT is not committed. The next cycle shows the reset outputs.
- **OK transfer latency:** data phase = 1 + WAIT_STATES cycles.
- **ERROR latency:** exactly 2 cycles, always, independent of WAIT_STATES.
- **Address phases while hreadyout=0** (WAIT, ERR1): ignored. The master must hold them per AHB rules.
- **Back-to-back transfers:** NONSEQ followed by SEQ with WAIT_STATES=0 sustains 1 transfer per cycle.
- **hsel deasserted during a data phase:** the slave still completes the data phase it owns.

## Test plan
- **Reset then write/read, WAIT_STATES=0:** write 0xDEADBEEF to 0x10, then read 0x10. Required: reads 0xDEADBEEF; `hreadyout` never low; `hresp=0`.
- **Byte write:** after preloading 0x11223344 at 0x20, write hsize=0, haddr=0x21, hwdata=0x0000AB00, hwstrb=4'b1111. Required: readback 0x1122AB44.
- **WAIT_STATES=3 read:** required response is `hreadyout` low for exactly 3 cycles, then high with correct `hrdata`. A 4-beat INCR burst takes 16 data cycles.
- **Out-of-range (MEM_DEPTH=1024, 32-bit):** write to 0x1000. Required: ERR1 (`hresp=1`, `hreadyout=0`) then ERR2 (`hresp=1`, `hreadyout=1`); the memory word at index 0 is unchanged.
- **Misaligned access:** a halfword at 0x3 errors. A NONSEQ presented during ERR2 is accepted and completes OKAY.
- **Reset mid-write:** assert `hreset` during WAIT of a write to 0x40 (WAIT_STATES=5). Required: the next cycle shows `hreadyout=1`, `hresp=0`; a later read of 0x40 returns the old data.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave fronting a word-addressed single-port SRAM.
// Supports programmable wait states, byte-lane writes and the two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int unsigned ADDRWIDTH   = 32,
  parameter int unsigned DATAWIDTH   = 32,
  parameter int unsigned MEM_DEPTH   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic                   hsel,
  input  logic [ADDRWIDTH-1:0]   haddr,
  input  logic [2:0]             hburst,
  input  logic [2:0]             hsize,
  input  logic [1:0]             htrans,
  input  logic                   hwrite,
  input  logic [DATAWIDTH-1:0]   hwdata,
  input  logic [DATAWIDTH/8-1:0] hwstrb,
  input  logic                   hready,
  output logic [DATAWIDTH-1:0]   hrdata,
  output logic                   hresp,
  output logic                   hreadyout
);

  localparam int unsigned BPW  = DATAWIDTH / 8;
  localparam int unsigned OFFW = $clog2(BPW);
  localparam int unsigned IDXW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t               state;
  state_t               state_d;
  logic [3:0]           wcnt;
  logic [3:0]           wcnt_d;
  logic                 ready_d;
  logic                 resp_d;
  logic                 pend;
  logic                 p_write;
  logic [IDXW-1:0]      p_idx;
  logic [BPW-1:0]       p_lanes;

  logic [DATAWIDTH-1:0] mem [MEM_DEPTH];

  logic                 accept_c;
  logic                 err_c;
  logic [OFFW-1:0]      off_c;
  logic [7:0]           nbytes_c;
  logic [BPW-1:0]       lanes_c;
  logic                 commit_c;
  logic [BPW-1:0]       wlanes_c;
  logic [IDXW-1:0]      rd_idx_c;
  logic [DATAWIDTH-1:0] rd_word_c;
  logic                 ld_c;

  // Burst type and the SEQ/NONSEQ distinction carry no behaviour here.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  // Address-phase decode: accept, error classification and lane mask.
  always_comb begin
    accept_c = hsel & hready & htrans[1] & hreadyout;
    off_c    = haddr[OFFW-1:0];
    nbytes_c = 8'd1 << hsize;
    err_c    = ((haddr >> OFFW) >= ADDRWIDTH'(MEM_DEPTH))
             | (hsize > 3'(OFFW))
             | (|(off_c & OFFW'(nbytes_c - 8'd1)));
    for (int i = 0; i < int'(BPW); i++) begin
      lanes_c[i] = (8'(i) >= 8'(off_c)) && (8'(i) < (8'(off_c) + nbytes_c));
    end
  end

  // Write commit happens on the edge closing an OK write data phase.
  always_comb begin
    commit_c = pend & hreadyout & p_write & ~hreset;
    wlanes_c = p_lanes & hwstrb;
  end

  // Read word with bypass of a write committing on the same edge.
  always_comb begin
    rd_idx_c  = (state == ST_WAIT) ? p_idx : haddr[OFFW +: IDXW];
    rd_word_c = mem[rd_idx_c];
    if (commit_c && (p_idx == rd_idx_c)) begin
      for (int i = 0; i < int'(BPW); i++) begin
        if (wlanes_c[i]) rd_word_c[8*i +: 8] = hwdata[8*i +: 8];
      end
    end
    if (state == ST_WAIT) begin
      ld_c = (wcnt == 4'd1) && !p_write;
    end else begin
      ld_c = accept_c && !err_c && !hwrite && (WAIT_STATES == 0);
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    wcnt_d  = wcnt;
    ready_d = 1'b1;
    resp_d  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          if (err_c) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_d = ST_WAIT;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        wcnt_d = wcnt - 4'd1;
        if (wcnt == 4'd1) state_d = ST_DONE;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
    ready_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
    resp_d  = (state_d == ST_ERR1) || (state_d == ST_ERR2);
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state     <= ST_IDLE;
      wcnt      <= 4'd0;
      pend      <= 1'b0;
      p_write   <= 1'b0;
      p_idx     <= '0;
      p_lanes   <= '0;
      hreadyout <= 1'b1;
      hresp     <= 1'b0;
      hrdata    <= '0;
    end else begin
      state     <= state_d;
      wcnt      <= wcnt_d;
      hreadyout <= ready_d;
      hresp     <= resp_d;
      if (hreadyout) pend <= accept_c & ~err_c;
      if (accept_c && !err_c) begin
        p_write <= hwrite;
        p_idx   <= haddr[OFFW +: IDXW];
        p_lanes <= lanes_c;
      end
      if (ld_c) hrdata <= rd_word_c;
    end
  end

  // SRAM array; contents are intentionally not reset.
  always_ff @(posedge hclk) begin
    if (commit_c) begin
      for (int i = 0; i < int'(BPW); i++) begin
        if (wlanes_c[i]) mem[p_idx][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Scoreboard bench for ahb_sram_slave: three instances with 0, 3 and 5 wait states share one master.
module tb_ahb_sram_slave;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  trans;
  } beat_t;

  typedef struct {
    logic        rd;
    logic        err;
    logic [31:0] data;
    int          waits;
  } exp_t;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [2:0]  hsel_v;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic        hready;
  logic [31:0] hrdata_a [3];
  logic        hresp_a  [3];
  logic        hro_a    [3];

  logic [31:0] mdl [3][1024];
  beat_t       beats [$];
  exp_t        sb [$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_dcyc;

  always #5 hclk = ~hclk;

  // Only one slave is ever addressed at a time, so the bus HREADY is the AND of all.
  assign hready = hro_a[0] & hro_a[1] & hro_a[2];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
    ahb_sram_slave #(
      .ADDRWIDTH  (32),
      .DATAWIDTH  (32),
      .MEM_DEPTH  (1024),
      .WAIT_STATES(WS)
    ) u_dut (
      .hclk     (hclk),
      .hreset   (hreset),
      .hsel     (hsel_v[g]),
      .haddr    (haddr),
      .hburst   (hburst),
      .hsize    (hsize),
      .htrans   (htrans),
      .hwrite   (hwrite),
      .hwdata   (hwdata),
      .hwstrb   (hwstrb),
      .hready   (hready),
      .hrdata   (hrdata_a[g]),
      .hresp    (hresp_a[g]),
      .hreadyout(hro_a[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic int ws_of(input int tgt);
    return (tgt == 0) ? 0 : ((tgt == 1) ? 3 : 5);
  endfunction

  function automatic void add(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                              input logic [31:0] wdata, input logic [3:0] strb, input logic [1:0] trans);
    beat_t b;
    b.wr = wr; b.addr = addr; b.size = size; b.wdata = wdata; b.strb = strb; b.trans = trans;
    beats.push_back(b);
  endfunction

  // Transfer-level reference: error decision, lane update of the model, expected response.
  function automatic exp_t expect_of(input int tgt, input beat_t b);
    exp_t e;
    int   idx = int'(b.addr >> 2);
    int   off = int'(b.addr[1:0]);
    int   nb  = 1 << int'(b.size);
    e.rd    = !b.wr;
    e.err   = (idx >= 1024) || (b.size > 3'd2) || ((int'(b.addr[7:0]) % nb) != 0);
    e.waits = e.err ? 1 : ws_of(tgt);
    e.data  = 32'h0;
    if (!e.err) begin
      if (b.wr) begin
        for (int k = 0; k < 4; k++) begin
          if (k >= off && k < off + nb && b.strb[k]) mdl[tgt][idx][8*k +: 8] = b.wdata[8*k +: 8];
        end
      end
      e.data = mdl[tgt][idx];
    end
    return e;
  endfunction

  // Pipelined master: drives the queued beats to one target and scores each data phase.
  task automatic run_seq(input int tgt);
    int    i   = 0;
    bit    dp  = 1'b0;
    int    wc  = 0;
    int    cyc = 0;
    beat_t db;
    exp_t  e;
    logic  rdy;
    last_dcyc = 0;
    while ((i < beats.size() || dp) && cyc < 300) begin
      if (i < beats.size()) begin
        hsel_v = 3'(3'b001 << tgt);
        haddr  = beats[i].addr;
        hsize  = beats[i].size;
        htrans = beats[i].trans;
        hwrite = beats[i].wr;
        hburst = 3'd1;
      end else begin
        hsel_v = 3'b000;
        htrans = 2'd0;
      end
      if (dp) begin
        hwdata = db.wdata;
        hwstrb = db.strb;
      end
      @(negedge hclk);
      rdy = hready;
      if (dp) begin
        last_dcyc++;
        if (!rdy) begin
          wc++;
          e = sb[0];
          check_eq("wait_resp", 32'(hresp_a[tgt]), 32'(e.err));
        end else begin
          e = sb.pop_front();
          check_eq("resp", 32'(hresp_a[tgt]), 32'(e.err));
          check_eq("waits", 32'(wc), 32'(e.waits));
          if (e.rd && !e.err) check_eq("rdata", hrdata_a[tgt], e.data);
          wc = 0;
        end
      end
      @(posedge hclk);
      #1;
      if (rdy) begin
        dp = 1'b0;
        if (i < beats.size()) begin
          sb.push_back(expect_of(tgt, beats[i]));
          db = beats[i];
          dp = 1'b1;
          i++;
        end
      end
      cyc++;
    end
    check_eq("seq_done", 32'(beats.size() - i + int'(dp)), 32'd0);
    hsel_v = 3'b000;
    htrans = 2'd0;
    beats.delete();
    sb.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1;
    hsel_v = 3'b000;
    haddr  = 32'h0;
    hburst = 3'd0;
    hsize  = 3'd2;
    htrans = 2'd0;
    hwrite = 1'b0;
    hwdata = 32'h0;
    hwstrb = 4'h0;
    for (int t = 0; t < 3; t++) for (int w = 0; w < 1024; w++) mdl[t][w] = 32'h0;
    repeat (2) @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    for (int t = 0; t < 3; t++) begin
      check_eq("rst_ready", 32'(hro_a[t]), 32'd1);
      check_eq("rst_resp", 32'(hresp_a[t]), 32'd0);
      check_eq("rst_rdata", hrdata_a[t], 32'h0);
    end
    @(posedge hclk);
    #1;

    // Zero-wait write then immediate read of the same word.
    add(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 2'd2);
    add(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(0);

    // Byte and halfword lane writes.
    add(1'b1, 32'h20, 3'd2, 32'h11223344, 4'hF, 2'd2);
    add(1'b1, 32'h21, 3'd0, 32'h0000AB00, 4'hF, 2'd2);
    add(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 2'd2);
    add(1'b1, 32'h22, 3'd1, 32'h77660000, 4'hF, 2'd2);
    add(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(0);

    // Back-to-back zero-wait bursts: one data cycle per beat.
    for (int k = 0; k < 4; k++) add(1'b1, 32'h80 + 32'(4*k), 3'd2, 32'hA0A0_0000 + 32'(k), 4'hF, (k == 0) ? 2'd2 : 2'd3);
    for (int k = 0; k < 4; k++) add(1'b0, 32'h80 + 32'(4*k), 3'd2, 32'h0, 4'h0, (k == 0) ? 2'd2 : 2'd3);
    run_seq(0);
    check_eq("b2b_cycles", 32'(last_dcyc), 32'd8);

    // Out-of-range write must leave word 0 untouched.
    add(1'b1, 32'h0, 3'd2, 32'h55AA55AA, 4'hF, 2'd2);
    add(1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, 4'hF, 2'd2);
    add(1'b0, 32'h0, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(0);

    // Misaligned halfword and oversize transfer; a NONSEQ in ERR2 is taken.
    add(1'b0, 32'h3, 3'd1, 32'h0, 4'h0, 2'd2);
    add(1'b0, 32'h10, 3'd2, 32'h0, 4'h0, 2'd2);
    add(1'b1, 32'h8, 3'd3, 32'h12345678, 4'hF, 2'd2);
    add(1'b0, 32'h20, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(0);

    // Random full writes, random-strobe overwrites, readback.
    for (int k = 0; k < 6; k++) begin
      add(1'b1, 32'h400 + 32'(4*k), 3'd2, $urandom, 4'hF, 2'd2);
      add(1'b1, 32'h400 + 32'(4*k), 3'd2, $urandom, 4'($urandom_range(0, 15)), 2'd2);
      add(1'b0, 32'h400 + 32'(4*k), 3'd2, 32'h0, 4'h0, 2'd2);
    end
    run_seq(0);

    // Three wait states: single transfers, then 4-beat INCR bursts.
    add(1'b1, 32'h30, 3'd2, 32'hC0FFEE00, 4'hF, 2'd2);
    add(1'b0, 32'h30, 3'd2, 32'h0, 4'h0, 2'd2);
    add(1'b1, 32'h1004, 3'd2, 32'h1, 4'hF, 2'd2);
    add(1'b0, 32'h30, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(1);
    for (int k = 0; k < 4; k++) add(1'b1, 32'h100 + 32'(4*k), 3'd2, 32'hB0B0_0000 + 32'(k), 4'hF, (k == 0) ? 2'd2 : 2'd3);
    run_seq(1);
    check_eq("burst_wr_cycles", 32'(last_dcyc), 32'(4 * (1 + ws_of(1))));
    for (int k = 0; k < 4; k++) add(1'b0, 32'h100 + 32'(4*k), 3'd2, 32'h0, 4'h0, (k == 0) ? 2'd2 : 2'd3);
    run_seq(1);
    check_eq("burst_rd_cycles", 32'(last_dcyc), 32'(4 * (1 + ws_of(1))));

    // Five wait states: reset during the wait of a write aborts it.
    add(1'b1, 32'h40, 3'd2, 32'hCAFEF00D, 4'hF, 2'd2);
    add(1'b0, 32'h40, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(2);
    hsel_v = 3'b100;
    haddr  = 32'h40;
    hsize  = 3'd2;
    htrans = 2'd2;
    hwrite = 1'b1;
    @(posedge hclk);
    #1;
    hsel_v = 3'b000;
    htrans = 2'd0;
    hwdata = 32'h0BAD0BAD;
    hwstrb = 4'hF;
    @(negedge hclk);
    check_eq("abort_in_wait", 32'(hro_a[2]), 32'd0);
    @(posedge hclk);
    #1;
    hreset = 1'b1;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check_eq("abort_ready", 32'(hro_a[2]), 32'd1);
    check_eq("abort_resp", 32'(hresp_a[2]), 32'd0);
    check_eq("abort_rdata", hrdata_a[2], 32'h0);
    @(posedge hclk);
    #1;
    add(1'b0, 32'h40, 3'd2, 32'h0, 4'h0, 2'd2);
    run_seq(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
